// File: rtl/fp32_pkg.sv
// Shared fp32 constants, operand class struct and unpacker FSM states.
package fp32_pkg;

  localparam int FP32_BIAS        = 127;
  localparam int FP32_EXP_DENORM  = -126;
  localparam int FP32_EXP_SPECIAL = 128;

  localparam int FP32_EXP_W  = 8;
  localparam int FP32_MANT_W = 23;
  localparam int FP32_SIG_W  = 24;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    HOLD
  } state_e;

  typedef struct packed {
    logic zero;
    logic denorm;
    logic norm;
    logic inf;
    logic nan;
  } fp32_class_t;

endpackage

// File: rtl/Fp32Decoder.sv
// Combinational fp32 field split and one-hot class decode.
module Fp32Decoder
  import fp32_pkg::*;
(
  input  logic [31:0]            in_data,
  output logic                   sign,
  output logic [FP32_EXP_W-1:0]  exp_raw,
  output logic [FP32_MANT_W-1:0] mant,
  output logic                   is_zero,
  output logic                   is_denorm,
  output logic                   is_norm,
  output logic                   is_inf,
  output logic                   is_nan
);

  logic exp_zero;
  logic exp_ones;
  logic mant_zero;

  always_comb begin
    sign      = in_data[31];
    exp_raw   = in_data[30:23];
    mant      = in_data[22:0];
    exp_zero  = (exp_raw == '0);
    exp_ones  = (exp_raw == '1);
    mant_zero = (mant == '0);
    is_zero   = exp_zero & mant_zero;
    is_denorm = exp_zero & ~mant_zero;
    is_norm   = ~exp_zero & ~exp_ones;
    is_inf    = exp_ones & mant_zero;
    is_nan    = exp_ones & ~mant_zero;
  end

endmodule

// File: rtl/fp32_unpacker.sv
// fp32 operand unpacker with iterative denormal normalization.
// Define FP32_UNPACK_DAZ_EN to flush denormals to zero (no NORM state/shifter).
module fp32_unpacker
  import fp32_pkg::*;
#(
  parameter int unsigned SHIFT_STEP = 1,
  parameter int unsigned EXP_W      = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sign,
  output logic signed [EXP_W-1:0] out_exp,
  output logic [FP32_SIG_W-1:0]   out_sig,
  output logic                    out_is_zero,
  output logic                    out_is_denorm,
  output logic                    out_is_norm,
  output logic                    out_is_inf,
  output logic                    out_is_nan
);

  logic                   dec_sign;
  logic [FP32_EXP_W-1:0]  dec_exp;
  logic [FP32_MANT_W-1:0] dec_mant;
  logic dec_zero, dec_denorm, dec_norm, dec_inf, dec_nan;

  Fp32Decoder u_dec (
    .in_data   (in_data),
    .sign      (dec_sign),
    .exp_raw   (dec_exp),
    .mant      (dec_mant),
    .is_zero   (dec_zero),
    .is_denorm (dec_denorm),
    .is_norm   (dec_norm),
    .is_inf    (dec_inf),
    .is_nan    (dec_nan)
  );

  state_e                  state_q, state_d;
  logic                    sign_q, sign_d;
  logic [EXP_W-1:0]        exp_q, exp_d;
  logic [FP32_SIG_W-1:0]   sig_q, sig_d;
  fp32_class_t             cls_q, cls_d;
  logic                    accept;
`ifndef FP32_UNPACK_DAZ_EN
  logic [3:0]              shamt;
`endif

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    sig_d    = sig_q;
    cls_d    = cls_q;
`ifndef FP32_UNPACK_DAZ_EN
    shamt    = 4'd0;
`endif
    in_ready = (state_q == IDLE) | ((state_q == HOLD) & out_ready);
    accept   = in_valid & in_ready;

    case (state_q)
      NORM: begin
`ifndef FP32_UNPACK_DAZ_EN
        // Leave NORM only once the registered significand is normalized.
        if (sig_q[FP32_SIG_W-1]) begin
          state_d = HOLD;
        end else begin
          shamt = (sig_q[FP32_SIG_W-1 -: SHIFT_STEP] == '0) ? 4'(SHIFT_STEP) : 4'd1;
          sig_d = sig_q << shamt;
          exp_d = exp_q - EXP_W'(shamt);
        end
`else
        state_d = IDLE;
`endif
      end
      HOLD: begin
        if (out_ready & ~in_valid) state_d = IDLE;
      end
      default: ;
    endcase

    if (accept) begin
      sign_d = dec_sign;
      cls_d  = '{zero: dec_zero, denorm: dec_denorm, norm: dec_norm,
                 inf: dec_inf, nan: dec_nan};
      state_d = HOLD;
      if (dec_norm) begin
        exp_d = EXP_W'(dec_exp) - EXP_W'(FP32_BIAS);
        sig_d = {1'b1, dec_mant};
      end else if (dec_zero) begin
        exp_d = '0;
        sig_d = '0;
      end else if (dec_inf | dec_nan) begin
        exp_d = EXP_W'(FP32_EXP_SPECIAL);
        sig_d = {1'b0, dec_mant};
      end else begin
`ifdef FP32_UNPACK_DAZ_EN
        cls_d.zero   = 1'b1;
        cls_d.denorm = 1'b0;
        exp_d        = '0;
        sig_d        = '0;
`else
        exp_d   = EXP_W'(FP32_EXP_DENORM);
        sig_d   = {1'b0, dec_mant};
        state_d = NORM;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      sig_q   <= '0;
      cls_q   <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      sig_q   <= sig_d;
      cls_q   <= cls_d;
    end
  end

  assign out_valid     = (state_q == HOLD);
  assign out_sign      = sign_q;
  assign out_exp       = exp_q;
  assign out_sig       = sig_q;
  assign out_is_zero   = cls_q.zero;
  assign out_is_denorm = cls_q.denorm;
  assign out_is_norm   = cls_q.norm;
  assign out_is_inf    = cls_q.inf;
  assign out_is_nan    = cls_q.nan;

endmodule

// File: tb/tb_fp32_unpacker.sv
// Directed bench for fp32_unpacker: two instances (SHIFT_STEP=1 and 8) on shared stimulus.
module tb_fp32_unpacker;

  localparam logic [4:0] C_ZERO = 5'b10000;
  localparam logic [4:0] C_DEN  = 5'b01000;
  localparam logic [4:0] C_NRM  = 5'b00100;
  localparam logic [4:0] C_NAN  = 5'b00001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_data = '0;

  logic               r1, v1, s1, z1, d1, n1, i1, q1;
  logic signed [9:0]  e1;
  logic [23:0]        g1;
  logic               r8, v8, s8, z8, d8, n8, i8, q8;
  logic signed [9:0]  e8;
  logic [23:0]        g8;

  int n_tot = 0;
  int n_bad = 0;

  fp32_unpacker #(.SHIFT_STEP(1), .EXP_W(10)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1), .in_data(in_data),
    .out_valid(v1), .out_ready(out_ready), .out_sign(s1), .out_exp(e1), .out_sig(g1),
    .out_is_zero(z1), .out_is_denorm(d1), .out_is_norm(n1), .out_is_inf(i1), .out_is_nan(q1)
  );

  fp32_unpacker #(.SHIFT_STEP(8), .EXP_W(10)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r8), .in_data(in_data),
    .out_valid(v8), .out_ready(out_ready), .out_sign(s8), .out_exp(e8), .out_sig(g8),
    .out_is_zero(z8), .out_is_denorm(d8), .out_is_norm(n8), .out_is_inf(i8), .out_is_nan(q8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_u1(input string t, input logic s, input int e,
                        input logic [23:0] g, input logic [4:0] c);
    check({t, ".valid"}, v1, 1);
    check({t, ".sign"}, s1, s);
    check({t, ".exp"}, e1, e);
    check({t, ".sig"}, g1, g);
    check({t, ".cls"}, {z1, d1, n1, i1, q1}, c);
  endtask

  task automatic accept(input logic [31:0] w);
    @(negedge clk);
    check("acc_ready", r1, 1);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    int f1;
    int f8;

    #12;
    check("rst.valid", v1, 0);
    check("rst.sig", g1, 0);
    check("rst.exp", e1, 0);
    check("rst.sign", s1, 0);
    check("rst.cls", {z1, d1, n1, i1, q1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst.ready", r1, 1);

    // 1.0: one-cycle latency
    accept(32'h3F80_0000);
    chk_u1("one", 1'b0, 0, 24'h80_0000, C_NRM);
    @(posedge clk);
    #1;
    check("one.idle", v1, 0);

`ifndef FP32_UNPACK_DAZ_EN
    // Smallest denormal on both shift widths
    accept(32'h0000_0001);
    n = 0; f1 = 0; f8 = 0;
    while ((f1 == 0 || f8 == 0) && n < 40) begin
      if (n == 5) begin
        check("norm.ready1", r1, 0);
        check("norm.ready8", r8, 0);
        check("norm.valid1", v1, 0);
      end
      @(posedge clk);
      #1;
      n++;
      if (f8 == 0 && v8) begin
        f8 = n;
        check("s8.exp", e8, -149);
        check("s8.sig", g8, 24'h80_0000);
        check("s8.sign", s8, 0);
        check("s8.cls", {z8, d8, n8, i8, q8}, C_DEN);
      end
      if (f1 == 0 && v1) begin
        f1 = n;
        chk_u1("s1", 1'b0, -149, 24'h80_0000, C_DEN);
      end
    end
    check("s1.latency", f1, 24);
    check("s8.latency", f8, 10);
    repeat (2) @(posedge clk);
    #1;

    // Negative smallest denormal: sign preserved through normalization
    accept(32'h8000_0001);
    n = 0;
    while (!v1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("nden.latency", n, 24);
    chk_u1("nden", 1'b1, -149, 24'h80_0000, C_DEN);
    repeat (2) @(posedge clk);
    #1;
`else
    accept(32'h8000_0001);
    chk_u1("daz", 1'b1, 0, 24'h00_0000, C_ZERO);
    @(posedge clk);
    #1;
`endif

    // NaN held under backpressure
    out_ready = 1'b0;
    accept(32'hFF80_0001);
    for (int k = 0; k < 5; k++) begin
      chk_u1("nan", 1'b1, 128, 24'h00_0001, C_NAN);
      check("nan.ready", r1, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    check("nan.release_ready", r1, 1);
    @(posedge clk);
    #1;
    check("nan.idle", v1, 0);

    // Back-to-back normals
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h4000_0000;
    @(posedge clk);
    #1;
    chk_u1("b2b0", 1'b0, 1, 24'h80_0000, C_NRM);
    in_data = 32'hC040_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk_u1("b2b1", 1'b1, 1, 24'hC0_0000, C_NRM);
    @(posedge clk);
    #1;
    check("b2b.idle", v1, 0);

    // Reset in the middle of normalization
    accept(32'h0000_0010);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst.valid", v1, 0);
    check("mrst.sig", g1, 0);
    check("mrst.cls", {z1, d1, n1, i1, q1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mrst.ready", r1, 1);
    accept(32'h3F80_0000);
    chk_u1("mrst.one", 1'b0, 0, 24'h80_0000, C_NRM);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
